// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the SPI bus arbiter.
//   state_t      - arbiter sequencing states
//   cli_idx_t    - client index (flash, shift register, MPU)
//   next_client  - round-robin successor of a client index
package spi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD
   } state_t;

   typedef logic [1:0] cli_idx_t;

   localparam int unsigned N_CLIENTS = 3;

   localparam cli_idx_t CLI_FLASH     = 2'd0;
   localparam cli_idx_t CLI_SHIFT_REG = 2'd1;
   localparam cli_idx_t CLI_MPU       = 2'd2;

   // Order flash -> shift_reg -> mpu -> flash.
   function automatic cli_idx_t next_client(input cli_idx_t c);
      return (c >= CLI_MPU) ? CLI_FLASH : cli_idx_t'(c + 2'd1);
   endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// spi_rr_pick: combinational round-robin selector.
//   req    in  N_CLIENTS  request vector
//   last   in  2          index of the most recently granted client
//   winner out N_CLIENTS  one-hot winner (all zero when no request)
//   idx    out 2          index of the winner (equals last when no request)
module spi_rr_pick
   import spi_arb_pkg::*;
(
   input  logic [N_CLIENTS-1:0] req,
   input  cli_idx_t             last,
   output logic [N_CLIENTS-1:0] winner,
   output cli_idx_t             idx
);

   cli_idx_t cand;
   logic     found;

   // Scan starting just after the last grant; the first requester found wins.
   always_comb begin
      winner = '0;
      idx    = last;
      found  = 1'b0;
      cand   = next_client(last);
      for (int k = 0; k < int'(N_CLIENTS); k++) begin
         if (!found && req[cand]) begin
            found       = 1'b1;
            idx         = cand;
            winner[cand] = 1'b1;
         end
         cand = next_client(cand);
      end
   end

endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one SPI master engine among flash, shift register and MPU
// clients with round-robin arbitration, sequencing CS setup, transfer and CS hold.
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_i/nrw_i [2:0]     per-client request level and direction (1 = write)
//   len_i [23:0]          per-client bit count, client k in [8k+7:8k]
//   grant_o, done_o [2:0] one-hot bus ownership, one-cycle completion pulse
//   err_o                 valid with done_o: bad length or timeout
//   rdata_o [15:0]        read data captured at the last completion
//   eng_*                 SPI engine launch/abort/length/direction and completion/data
//   cs_*_o                active-high chip selects, identical to grant_o
module spi_bus_arbiter
   import spi_arb_pkg::*;
#(
   parameter int unsigned CS_SETUP_CYC = 2,
   parameter int unsigned CS_HOLD_CYC  = 3,
   parameter int unsigned TIMEOUT_CYC  = 1024,
   parameter int unsigned MAX_BITS     = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [2:0]  req_i,
   input  logic [2:0]  nrw_i,
   input  logic [23:0] len_i,
   output logic [2:0]  grant_o,
   output logic [2:0]  done_o,
   output logic        err_o,
   output logic [15:0] rdata_o,
   output logic        eng_start_o,
   output logic        eng_abort_o,
   output logic [7:0]  eng_len_o,
   output logic        eng_nrw_o,
   input  logic        eng_done_i,
   input  logic [15:0] eng_rdata_i,
   output logic        cs_flash_o,
   output logic        cs_shift_reg_o,
   output logic        cs_mpu_o
);

   localparam int unsigned CNT_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);
   localparam int unsigned TW      = $clog2(TIMEOUT_CYC + 1);

   localparam logic [CW-1:0] SETUP_LOAD = CW'(CS_SETUP_CYC - 1);
   localparam logic [CW-1:0] HOLD_LOAD  = CW'(CS_HOLD_CYC - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]    MAX_LEN    = 8'(MAX_BITS);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   cli_idx_t        last_q, last_d;
   cli_idx_t        win_q, win_d;
   logic [2:0]      grant_q, grant_d;
   logic [2:0]      done_q, done_d;
   logic            err_q, err_d;
   logic [15:0]     rdata_q, rdata_d;
   logic            start_q, start_d;
   logic            abort_q, abort_d;
   logic [7:0]      len_q, len_d;
   logic            nrw_q, nrw_d;

   logic [2:0]      pick_winner;
   cli_idx_t        pick_idx;
   logic [7:0]      sel_len;
   logic            len_ok;

   spi_rr_pick u_pick (
      .req    (req_i),
      .last   (last_q),
      .winner (pick_winner),
      .idx    (pick_idx)
   );

   always_comb begin
      case (pick_idx)
         CLI_SHIFT_REG: sel_len = len_i[15:8];
         CLI_MPU:       sel_len = len_i[23:16];
         default:       sel_len = len_i[7:0];
      endcase
   end

   assign len_ok = (sel_len != 8'd0) && (sel_len <= MAX_LEN);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      last_d  = last_q;
      win_d   = win_q;
      grant_d = grant_q;
      done_d  = 3'b000;
      err_d   = 1'b0;
      rdata_d = rdata_q;
      start_d = 1'b0;
      abort_d = 1'b0;
      len_d   = len_q;
      nrw_d   = nrw_q;

      unique case (state_q)
         IDLE: begin
            if (|req_i) begin
               win_d = pick_idx;
               len_d = sel_len;
               nrw_d = nrw_i[pick_idx];
               if (len_ok) begin
                  state_d = SETUP;
                  grant_d = pick_winner;
                  cnt_d   = SETUP_LOAD;
               end else begin
                  // Rejected without touching CS or the engine.
                  state_d = HOLD;
                  done_d  = pick_winner;
                  err_d   = 1'b1;
                  last_d  = pick_idx;
                  cnt_d   = HOLD_LOAD;
               end
            end
         end

         SETUP: begin
            if (cnt_q == '0) begin
               state_d = XFER;
               start_d = 1'b1;
               tmo_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         XFER: begin
            // Completion wins over a timeout expiring on the same cycle.
            if (eng_done_i) begin
               state_d = HOLD;
               rdata_d = eng_rdata_i;
               done_d  = grant_q;
               grant_d = 3'b000;
               last_d  = win_q;
               cnt_d   = HOLD_LOAD;
            end else if (tmo_q == TMO_LAST) begin
               state_d = HOLD;
               rdata_d = 16'h0000;
               abort_d = 1'b1;
               err_d   = 1'b1;
               done_d  = grant_q;
               grant_d = 3'b000;
               last_d  = win_q;
               cnt_d   = HOLD_LOAD;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end

         HOLD: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tmo_q   <= '0;
         last_q  <= CLI_MPU;  // flash is next, so it has top priority
         win_q   <= CLI_FLASH;
         grant_q <= 3'b000;
         done_q  <= 3'b000;
         err_q   <= 1'b0;
         rdata_q <= 16'h0000;
         start_q <= 1'b0;
         abort_q <= 1'b0;
         len_q   <= 8'h00;
         nrw_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         last_q  <= last_d;
         win_q   <= win_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         start_q <= start_d;
         abort_q <= abort_d;
         len_q   <= len_d;
         nrw_q   <= nrw_d;
      end
   end

   assign grant_o        = grant_q;
   assign done_o         = done_q;
   assign err_o          = err_q;
   assign rdata_o        = rdata_q;
   assign eng_start_o    = start_q;
   assign eng_abort_o    = abort_q;
   assign eng_len_o      = len_q;
   assign eng_nrw_o      = nrw_q;
   assign cs_flash_o     = grant_q[CLI_FLASH];
   assign cs_shift_reg_o = grant_q[CLI_SHIFT_REG];
   assign cs_mpu_o       = grant_q[CLI_MPU];

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed self-checking bench for spi_bus_arbiter with default
// parameters (setup 2, hold 3, timeout 1024, max 16 bits).
module tb_spi_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [2:0]  nrw;
   logic [23:0] len;
   logic [2:0]  grant;
   logic [2:0]  done;
   logic        err;
   logic [15:0] rdata;
   logic        eng_start;
   logic        eng_abort;
   logic [7:0]  eng_len;
   logic        eng_nrw;
   logic        eng_done;
   logic [15:0] eng_rdata;
   logic        cs_flash;
   logic        cs_shift_reg;
   logic        cs_mpu;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   spi_bus_arbiter dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_i          (req),
      .nrw_i          (nrw),
      .len_i          (len),
      .grant_o        (grant),
      .done_o         (done),
      .err_o          (err),
      .rdata_o        (rdata),
      .eng_start_o    (eng_start),
      .eng_abort_o    (eng_abort),
      .eng_len_o      (eng_len),
      .eng_nrw_o      (eng_nrw),
      .eng_done_i     (eng_done),
      .eng_rdata_i    (eng_rdata),
      .cs_flash_o     (cs_flash),
      .cs_shift_reg_o (cs_shift_reg),
      .cs_mpu_o       (cs_mpu)
   );

   // Outputs are observed 1 time unit after the active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {grant, done, err, eng_start, eng_abort, eng_nrw, eng_len, cs_mpu, cs_shift_reg,
              cs_flash} ^ {16'h0, rdata};
   endfunction

   logic [2:0] rr_exp [4];
   int         low;
   logic       seen;

   initial begin
      rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
      rst = 1'b1; req = '0; nrw = '0; len = '0; eng_done = 1'b0; eng_rdata = '0;
      step(); step();
      check("reset_outputs", all_outs(), 32'h0);
      check("reset_rdata", {16'h0, rdata}, 32'h0);
      rst = 1'b0;

      // Single flash read: cycle 0 request.
      req = 3'b001; len = 24'h000008; nrw = 3'b000;
      step();  // cycle 1
      check("rd_cs_c1", {29'h0, cs_mpu, cs_shift_reg, cs_flash}, 32'b001);
      check("rd_grant_c1", {29'h0, grant}, 32'b001);
      check("rd_start_c1", {31'h0, eng_start}, 32'h0);
      req = 3'b000;  // request drops mid-transaction
      step();  // cycle 2
      check("rd_start_c2", {31'h0, eng_start}, 32'h0);
      step();  // cycle 3
      check("rd_start_c3", {31'h0, eng_start}, 32'h1);
      check("rd_eng_len", {24'h0, eng_len}, 32'd8);
      check("rd_eng_nrw", {31'h0, eng_nrw}, 32'h0);
      step();  // cycle 4
      check("rd_start_c4", {31'h0, eng_start}, 32'h0);
      step(); step();  // cycle 6
      check("rd_cs_c6", {31'h0, cs_flash}, 32'h1);
      eng_done = 1'b1; eng_rdata = 16'h00A5;
      step();  // cycle 7
      eng_done = 1'b0; eng_rdata = 16'h0000;
      check("rd_cs_c7", {29'h0, cs_mpu, cs_shift_reg, cs_flash}, 32'h0);
      check("rd_done", {29'h0, done}, 32'b001);
      check("rd_err", {31'h0, err}, 32'h0);
      check("rd_rdata", {16'h0, rdata}, 32'h00A5);
      step();  // cycle 8
      check("rd_done_pulse", {29'h0, done}, 32'h0);
      check("rd_rdata_hold", {16'h0, rdata}, 32'h00A5);
      step(); step();  // cycle 10: IDLE

      // Round-robin from reset with all clients requesting.
      rst = 1'b1; step(); rst = 1'b0;
      req = 3'b111; len = 24'h040404; nrw = 3'b000;
      step();
      for (int g = 0; g < 4; g++) begin
         check($sformatf("rr_grant%0d", g), {29'h0, grant}, {29'h0, rr_exp[g]});
         check($sformatf("rr_cs%0d", g), {29'h0, cs_mpu, cs_shift_reg, cs_flash},
               {29'h0, rr_exp[g]});
         step(); step();
         check($sformatf("rr_start%0d", g), {31'h0, eng_start}, 32'h1);
         eng_done = 1'b1; eng_rdata = 16'h1000 + 16'(g);
         step();
         eng_done = 1'b0;
         check($sformatf("rr_done%0d", g), {29'h0, done}, {29'h0, rr_exp[g]});
         check($sformatf("rr_rdata%0d", g), {16'h0, rdata}, 32'h1000 + g);
         if (g == 3) req = 3'b000;
         low = 0;
         for (int k = 0; k < 12 && grant == 3'b000; k++) begin
            low++;
            step();
         end
         if (g < 3) check($sformatf("rr_gap%0d", g), low, 32'd4);
      end

      // Bad length: mpu len 0, then 17.
      req = 3'b100; len = 24'h000000;
      step();  // cycle 1
      req = 3'b000;
      check("bl0_done", {29'h0, done}, 32'b100);
      check("bl0_err", {31'h0, err}, 32'h1);
      check("bl0_cs", {29'h0, cs_mpu, cs_shift_reg, cs_flash}, 32'h0);
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         seen = seen | eng_start | (|grant);
      end
      req = 3'b100; len = 24'h110000;
      step();
      req = 3'b000;
      check("bl17_done", {29'h0, done}, 32'b100);
      check("bl17_err", {31'h0, err}, 32'h1);
      check("bl17_cs", {29'h0, cs_mpu, cs_shift_reg, cs_flash}, 32'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         seen = seen | eng_start | (|grant);
      end
      check("bl_no_start", {31'h0, seen}, 32'h0);

      // Timeout: flash write, engine silent.
      req = 3'b001; len = 24'h000010; nrw = 3'b001;
      step(); req = 3'b000;
      step(); step();  // start cycle
      check("to_start", {31'h0, eng_start}, 32'h1);
      check("to_eng_len", {24'h0, eng_len}, 32'd16);
      check("to_eng_nrw", {31'h0, eng_nrw}, 32'h1);
      seen = 1'b0;
      for (int k = 0; k < 1023; k++) begin
         step();
         seen = seen | eng_abort;
      end
      check("to_no_early_abort", {31'h0, seen}, 32'h0);
      check("to_cs_before", {31'h0, cs_flash}, 32'h1);
      step();  // start + TIMEOUT_CYC
      check("to_abort", {31'h0, eng_abort}, 32'h1);
      check("to_err", {31'h0, err}, 32'h1);
      check("to_done", {29'h0, done}, 32'b001);
      check("to_rdata", {16'h0, rdata}, 32'h0);
      check("to_cs", {31'h0, cs_flash}, 32'h0);
      step();
      check("to_abort_pulse", {31'h0, eng_abort}, 32'h0);
      step(); step();  // IDLE

      // Done on the timeout expiry cycle counts as success.
      req = 3'b010; len = 24'h000C00; nrw = 3'b000;
      step(); req = 3'b000;
      step(); step();
      check("col_start", {31'h0, eng_start}, 32'h1);
      for (int k = 0; k < 1023; k++) step();
      check("col_cs_before", {31'h0, cs_shift_reg}, 32'h1);
      eng_done = 1'b1; eng_rdata = 16'hBEEF;
      step();
      eng_done = 1'b0; eng_rdata = 16'h0000;
      check("col_abort", {31'h0, eng_abort}, 32'h0);
      check("col_err", {31'h0, err}, 32'h0);
      check("col_done", {29'h0, done}, 32'b010);
      check("col_rdata", {16'h0, rdata}, 32'hBEEF);
      step(); step(); step();  // IDLE

      // Stray engine completion in IDLE is ignored.
      eng_done = 1'b1; eng_rdata = 16'h1234;
      step();
      eng_done = 1'b0; eng_rdata = 16'h0000;
      check("stray_rdata", {16'h0, rdata}, 32'hBEEF);
      check("stray_done", {29'h0, done}, 32'h0);

      // Reset during a shift_reg transfer.
      req = 3'b010; len = 24'h000800;
      step(); req = 3'b000;
      step(); step(); step();  // in XFER
      check("rst_cs_before", {31'h0, cs_shift_reg}, 32'h1);
      rst = 1'b1;
      step();
      check("rst_outputs", all_outs(), 32'h0);
      check("rst_rdata", {16'h0, rdata}, 32'h0);
      rst = 1'b0;
      req = 3'b111; len = 24'h080808;
      step();
      check("rst_first_grant", {29'h0, grant}, 32'b001);
      req = 3'b000;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Shares the single SPI master engine among three clients (flash, shift register, MPU) using round-robin arbitration. For each granted client it sequences a complete transaction:
- assert that client's chip select,
- wait a setup delay,
- launch the engine and wait for completion or timeout,
- deassert chip select and enforce an inter-transaction hold gap.

It sits between the client controllers and the SPI master engine, and owns the chip-select outputs.

## Interface
Parameters:
- CS_SETUP_CYC, 2, cycles from CS assertion to engine start (≥1)
- CS_HOLD_CYC, 3, idle cycles after CS deassertion before the next grant (≥1)
- TIMEOUT_CYC, 1024, max cycles in XFER waiting for eng_done_i
- MAX_BITS, 16, largest legal transfer length

Ports:
- clk_i  in  1  base clock; single clock domain
- rst_i  in  1  synchronous, active-high reset
- req_i  in  3  per-client request level; bit 0 flash, 1 shift_reg, 2 mpu
- nrw_i  in  3  per-client direction: 0 read, 1 write
- len_i  in  24  per-client bit count; client k uses [8k+7:8k]
- grant_o  out  3  one-hot; high while a client owns the bus
- done_o  out  3  one-cycle completion pulse per client
- err_o  out  1  valid with done_o: 1 means bad length or timeout
- rdata_o  out  16  captured engine read data
- eng_start_o  out  1  one-cycle engine launch pulse
- eng_abort_o  out  1  one-cycle abort pulse on timeout
- eng_len_o  out  8  latched length
- eng_nrw_o  out  1  latched direction
- eng_done_i  in  1  engine completion pulse
- eng_rdata_i  in  16  engine read data; valid with eng_done_i
- cs_flash_o, cs_shift_reg_o, cs_mpu_o  out  1 each  active-high chip selects

## Operation
- **Reset:** every output is 0 and the state is IDLE. The round-robin pointer is set so flash has top priority.
- **IDLE**
  - If any req_i bit is high, the next requester after the last-granted client wins (order flash→shift_reg→mpu→flash).
  - The block latches the winner's index, len and nrw.
  - If len is in 1..MAX_BITS: go to SETUP and register grant_o and CS for the winner.
  - Otherwise: go to HOLD with err_o=1. No CS is asserted and the engine is not started.
- **SETUP:** counts CS_SETUP_CYC cycles, then goes to XFER.
- **XFER**
  - eng_start_o is high on the first XFER cycle only.
  - eng_len_o and eng_nrw_o hold the latched values from IDLE exit until IDLE re-entry.
  - On eng_done_i: capture eng_rdata_i into rdata_o, then go to HOLD with err_o=0.
  - If TIMEOUT_CYC cycles elapse without eng_done_i: pulse eng_abort_o, set rdata_o=0, go to HOLD with err_o=1.
- **HOLD**
  - On the entry cycle: CS and grant_o drop, done_o[winner] pulses, err_o is valid, and the round-robin pointer advances to the winner.
  - Stays CS_HOLD_CYC cycles, then returns to IDLE.
- At most one CS is high at any time. CS always equals grant_o.
- **Boundary rules**
  - req_i may drop during a transaction; the transaction still completes and done_o still pulses.
  - eng_done_i outside XFER is ignored.
  - eng_done_i on the same cycle as timeout expiry counts as success; no abort is issued.
  - rdata_o holds its value until the next completion.
  - rst_i mid-transaction clears everything on the next edge. eng_abort_o is not pulsed, because the engine shares rst_i.

## Timing
- A request first seen in IDLE at cycle 0 gives CS/grant high at cycle 1 and eng_start_o at cycle 1+CS_SETUP_CYC.
- eng_done_i at cycle D gives done_o plus CS low at D+1, and IDLE at D+1+CS_HOLD_CYC.
- The earliest next CS assertion is D+CS_HOLD_CYC+2.
- A bad-length request pulses done_o/err_o at cycle 1.
- All outputs are registered. The arbitration pick is combinational from registered state and req_i.

## Structure
- **Package spi_arb_pkg** contains:
  - state_t {IDLE, SETUP, XFER, HOLD}
  - CLI_FLASH=0, CLI_SHIFT_REG=1, CLI_MPU=2, N_CLIENTS=3
- **Sub-module spi_rr_pick:** combinational round-robin selector. Inputs are the req vector and the last-grant pointer; outputs are the one-hot winner and its index.
- **Counters:** one shared down-counter for SETUP/HOLD. A separate timeout counter of width $clog2(TIMEOUT_CYC+1).

## Test plan
- **Single flash read:** req_i=001, len=8, nrw=0; engine returns 0xA5 three cycles after start → cs_flash_o high cycles 1..6, eng_start_o at cycle 3, rdata_o=0x00A5, done_o=001, err_o=0.
- **Round-robin:** req_i=111 held → grants in order 001,010,100,001, with exactly CS_HOLD_CYC+1 CS-low cycles between grants.
- **Bad length:** mpu len=0, then mpu len=17 → no CS, no eng_start_o, done_o=100 with err_o=1 at cycle 1 each time.
- **Timeout:** engine never responds → eng_abort_o at start+TIMEOUT_CYC, err_o=1, rdata_o=0, CS dropped the same cycle.
- **Done/timeout collision:** eng_done_i on the expiry cycle → err_o=0, no eng_abort_o, data captured.
- **Reset mid-XFER:** rst_i during shift_reg transfer → all outputs 0 next cycle; a following req_i=111 grants flash first.
